// File: rtl/wb_arbiter_scoreboard_if.sv
// Writeback bus between the issue, ALU and memory sources and the register-file write port.
// The DUT uses the slave side; the driving environment uses the master side.
interface wb_arbiter_scoreboard_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            mem_valid;
    logic            mem_ready;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic [31:0]     busy;
    logic [CW-1:0]   fifo_count;
    logic            WE3;
    logic [4:0]      A3;
    logic [XLEN-1:0] WD3;

    modport slave (
        input  issue_valid, issue_rd,
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready, busy, fifo_count,
        output WE3, A3, WD3
    );

    modport master (
        output issue_valid, issue_rd,
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready, busy, fifo_count,
        input  WE3, A3, WD3
    );
endinterface

// File: rtl/wb_arbiter_scoreboard.sv
// Writeback arbiter: ALU results take priority over buffered memory returns on the register-file
// write port; a per-register busy scoreboard tracks destinations that have not yet committed.
module wb_arbiter_scoreboard #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    wb_arbiter_scoreboard_if.slave bus
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [4:0]      r_fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0] r_fifo_data [FIFO_DEPTH];

    logic            r_we3;
    logic [4:0]      r_a3;
    logic [XLEN-1:0] r_wd3;
    logic [31:1]     r_busy;

    logic            w_mem_ready;
    logic            w_push;
    logic            w_pop;
    logic [4:0]      w_head_rd;
    logic [XLEN-1:0] w_head_data;
    logic [31:1]     w_busy_d;

    // Ready comes only from the registered count, so a full FIFO never takes a same-cycle push.
    assign w_mem_ready = (r_count < CW'(FIFO_DEPTH));
    assign w_push      = bus.mem_valid && w_mem_ready;
    assign w_pop       = !bus.alu_valid && (r_count != '0);
    assign w_head_rd   = r_fifo_rd[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];

    // Set (new issue) wins over clear (write committing at this same edge).
    always_comb begin
        w_busy_d = r_busy;
        for (int r = 1; r < 32; r++) begin
            if (bus.issue_valid && (bus.issue_rd == 5'(r))) begin
                w_busy_d[r] = 1'b1;
            end else if (r_we3 && (r_a3 == 5'(r))) begin
                w_busy_d[r] = 1'b0;
            end
        end
    end

    // Storage needs no reset: only entries below r_count are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= bus.mem_rd;
            r_fifo_data[r_wptr] <= bus.mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_we3   <= 1'b0;
            r_a3    <= '0;
            r_wd3   <= '0;
            r_busy  <= '0;
        end else begin
            r_busy <= w_busy_d;

            if (bus.alu_valid) begin
                r_we3 <= (bus.alu_rd != 5'd0);
                r_a3  <= bus.alu_rd;
                r_wd3 <= bus.alu_data;
            end else if (w_pop) begin
                r_we3 <= (w_head_rd != 5'd0);
                r_a3  <= w_head_rd;
                r_wd3 <= w_head_data;
            end else begin
                r_we3 <= 1'b0;
            end

            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.mem_ready  = w_mem_ready;
    assign bus.fifo_count = r_count;
    assign bus.busy       = {r_busy, 1'b0};
    assign bus.WE3        = r_we3;
    assign bus.A3         = r_a3;
    assign bus.WD3        = r_wd3;

endmodule

// File: tb/tb_wb_arbiter_scoreboard.sv
// Randomized and directed bench for wb_arbiter_scoreboard against a queue-based reference model
// of the writeback rules.
module tb_wb_arbiter_scoreboard;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    logic clk;
    logic rst_n;

    wb_arbiter_scoreboard_if #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) bus ();

    wb_arbiter_scoreboard #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    entry_t          m_q[$];
    logic            m_we;
    logic [4:0]      m_a;
    logic [XLEN-1:0] m_wd;
    logic [31:0]     m_busy;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_we   = 1'b0;
        m_a    = '0;
        m_wd   = '0;
        m_busy = '0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".WE3"}, 64'(bus.WE3), 64'(m_we));
        if (m_we) begin
            check_eq({tag, ".A3"}, 64'(bus.A3), 64'(m_a));
            check_eq({tag, ".WD3"}, 64'(bus.WD3), 64'(m_wd));
        end
        check_eq({tag, ".busy"}, 64'(bus.busy), 64'(m_busy));
        check_eq({tag, ".count"}, 64'(bus.fifo_count), 64'(m_q.size()));
        check_eq({tag, ".ready"}, 64'(bus.mem_ready), 64'(m_q.size() < DEPTH));
    endtask

    // Drive one cycle of inputs, advance the model, clock, then compare 1ns after the edge.
    task automatic cycle(input string tag,
                         input bit iv, input logic [4:0] ird,
                         input bit av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                         input bit mv, input logic [4:0] mrd, input logic [XLEN-1:0] md);
        logic [31:0] nb;
        bit          ready;
        entry_t      e;
        bus.issue_valid = iv;
        bus.issue_rd    = ird;
        bus.alu_valid   = av;
        bus.alu_rd      = ard;
        bus.alu_data    = ad;
        bus.mem_valid   = mv;
        bus.mem_rd      = mrd;
        bus.mem_data    = md;

        ready = (m_q.size() < DEPTH);
        nb    = m_busy;
        for (int r = 1; r < 32; r++) begin
            if (iv && ird == 5'(r))          nb[r] = 1'b1;
            else if (m_we && m_a == 5'(r))   nb[r] = 1'b0;
        end
        if (av) begin
            m_we = (ard != 0); m_a = ard; m_wd = ad;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_we = (e.rd != 0); m_a = e.rd; m_wd = e.data;
        end else begin
            m_we = 1'b0;
        end
        if (mv && ready) begin
            e.rd = mrd; e.data = md;
            m_q.push_back(e);
        end
        m_busy = nb;

        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.mem_valid   = 1'b0;
        bus.mem_rd      = '0;
        bus.mem_data    = '0;
        model_reset();

        #12;
        check_eq("rst.WE3", 64'(bus.WE3), 64'd0);
        check_eq("rst.A3", 64'(bus.A3), 64'd0);
        check_eq("rst.WD3", 64'(bus.WD3), 64'd0);
        check_eq("rst.busy", 64'(bus.busy), 64'd0);
        check_eq("rst.count", 64'(bus.fifo_count), 64'd0);
        check_eq("rst.ready", 64'(bus.mem_ready), 64'd1);
        rst_n = 1'b1;
        idle("idle0");
        idle("idle1");

        // ALU write with scoreboard set/clear
        cycle("iss5", 1, 5, 0, 0, 0, 0, 0, 0);
        check_eq("iss5.busy5", 64'(bus.busy[5]), 64'd1);
        cycle("alu5", 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        check_eq("alu5.WE3", 64'(bus.WE3), 64'd1);
        check_eq("alu5.A3", 64'(bus.A3), 64'd5);
        check_eq("alu5.WD3", 64'(bus.WD3), 64'hDEADBEEF);
        check_eq("alu5.busy5", 64'(bus.busy[5]), 64'd1);
        idle("clr5");
        check_eq("clr5.busy5", 64'(bus.busy[5]), 64'd0);

        // Fill FIFO under a continuous ALU stream, fifth push refused
        for (int i = 1; i <= 5; i++) begin
            cycle("fill", 0, 0, 1, 9, 32'h900 + i, 1, 5'(i), 32'h100 + i);
        end
        check_eq("full.count", 64'(bus.fifo_count), 64'd4);
        check_eq("full.ready", 64'(bus.mem_ready), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            idle("drain");
            check_eq("drain.A3", 64'(bus.A3), 64'(i));
            check_eq("drain.WD3", 64'(bus.WD3), 64'(32'h100 + i));
        end
        idle("drained");
        check_eq("drained.WE3", 64'(bus.WE3), 64'd0);

        // x0 writes are consumed but never enabled
        cycle("x0alu", 0, 0, 1, 0, 32'h1234, 1, 0, 32'h5678);
        check_eq("x0alu.WE3", 64'(bus.WE3), 64'd0);
        check_eq("x0alu.count", 64'(bus.fifo_count), 64'd1);
        idle("x0mem");
        check_eq("x0mem.WE3", 64'(bus.WE3), 64'd0);
        check_eq("x0mem.count", 64'(bus.fifo_count), 64'd0);
        check_eq("x0mem.busy0", 64'(bus.busy[0]), 64'd0);

        // Re-issue to a register whose write commits on the same edge
        cycle("iss7", 1, 7, 0, 0, 0, 0, 0, 0);
        cycle("alu7", 0, 0, 1, 7, 32'h77, 0, 0, 0);
        cycle("iss7b", 1, 7, 0, 0, 0, 0, 0, 0);
        check_eq("iss7b.busy7", 64'(bus.busy[7]), 64'd1);
        idle("after7");
        check_eq("after7.busy7", 64'(bus.busy[7]), 64'd1);

        // Push+pop at count 2, streamed across several pointer wraps
        cycle("pp0", 0, 0, 1, 3, 32'h33, 1, 11, 32'hA000);
        cycle("pp1", 0, 0, 1, 3, 32'h34, 1, 12, 32'hA001);
        for (int i = 2; i < 14; i++) begin
            cycle("pp", 0, 0, 0, 0, 0, 1, 5'(11 + (i % 16)), 32'hA000 + i);
            check_eq("pp.count", 64'(bus.fifo_count), 64'd2);
        end
        idle("ppd0");
        idle("ppd1");
        idle("ppd2");

        // Asynchronous reset mid-drain
        for (int i = 1; i <= 4; i++) begin
            cycle("rfill", 1, 5'(20 + i), 1, 2, 32'h22, 1, 5'(i), 32'h200 + i);
        end
        idle("rdrain");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst.WE3", 64'(bus.WE3), 64'd0);
        check_eq("arst.A3", 64'(bus.A3), 64'd0);
        check_eq("arst.WD3", 64'(bus.WD3), 64'd0);
        check_eq("arst.busy", 64'(bus.busy), 64'd0);
        check_eq("arst.count", 64'(bus.fifo_count), 64'd0);
        check_eq("arst.ready", 64'(bus.mem_ready), 64'd1);
        #2;
        rst_n = 1'b1;
        idle("post_rst");

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            cycle("rand",
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom(),
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
